// File: rtl/seg_display_mux.sv
// Purpose : time-multiplexed driver for a two-digit common-anode 7-segment display.
// Latency : a val/bright change is visible from the next SHOW0 slot (at most one frame plus one cycle).
// Backpres: none; the display is a free-running sink and the inputs are sampled once per frame.
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-high; outputs blank immediately on assertion
//   val     [3:0] right digit, [7:4] left digit (hex)
//   bright  brightness 0 (dimmest) .. 7 (full); on-time = (bright+1)/8 of a slot
//   seg     active-low cathodes {g,f,e,d,c,b,a}
//   an      active-low anode enables; an[0] right digit, an[1] left digit
//
// Build option: define SEG_LEADING_ZERO_BLANK_EN to keep the left digit dark
// whenever it is zero. Timing and state sequence are unaffected.
module seg_display_mux #(
  parameter int REFRESH_DIV = 24000,  // lit-slot length in cycles, multiple of 8, >= 8
  parameter int DEAD_CYCLES = 480     // blanking between slots, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] val,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int SLOT    = REFRESH_DIV / 8;

  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW1  = 2'd1,
    BLANK1 = 2'd2,
    SHOW0  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    snap_val;
  logic [2:0]    snap_bright;
  // Set while reset is held and cleared on the first edge after release.
  // The release itself lands mid-period, so that first edge only arms the
  // counter; BLANK1 then holds for DEAD_CYCLES full edges before SHOW0.
  logic          boot;

  logic [3:0]    factor;
  logic [CW+3:0] on_lim;
  logic          lit;

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State register, slot counter and frame snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BLANK1;
      cnt         <= '0;
      snap_val    <= 8'h00;
      snap_bright <= 3'd7;
      boot        <= 1'b1;
    end else if (boot) begin
      boot <= 1'b0;
    end else if (state_nxt != state) begin
      state <= state_nxt;
      cnt   <= '0;
      // Both digits of a frame are drawn from this one capture.
      if (state_nxt == SHOW0) begin
        snap_val    <= val;
        snap_bright <= bright;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (!boot) begin
      case (state)
        SHOW0:   if (cnt == SHOW_LAST) state_nxt = BLANK0;
        BLANK0:  if (cnt == DEAD_LAST) state_nxt = SHOW1;
        SHOW1:   if (cnt == SHOW_LAST) state_nxt = BLANK1;
        BLANK1:  if (cnt == DEAD_LAST) state_nxt = SHOW0;
        default: state_nxt = BLANK1;
      endcase
    end
  end

  // Outputs depend only on registered state, cnt and snapshot, so a
  // mid-frame change on val/bright cannot reach the pins.
  always_comb begin
    an     = 2'b11;
    seg    = 7'h7F;
    // On-time threshold: (snap_bright+1) slices of REFRESH_DIV/8 cycles.
    factor = {1'b0, snap_bright} + 4'd1;
    on_lim = (CW+4)'(factor) * (CW+4)'(SLOT);
    lit    = {4'b0000, cnt} < on_lim;
    case (state)
      SHOW0: begin
        if (lit) begin
          an  = 2'b10;
          seg = decode(snap_val[3:0]);
        end
      end
      SHOW1: begin
        if (lit) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
          if (snap_val[7:4] != 4'h0) begin
            an  = 2'b01;
            seg = decode(snap_val[7:4]);
          end
`else
          an  = 2'b01;
          seg = decode(snap_val[7:4]);
`endif
        end
      end
      default: begin
        an  = 2'b11;
        seg = 7'h7F;
      end
    endcase
  end

endmodule
